// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant,
// last-winner rotation and an optional hold limit that forces release.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic HOLD_EN = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [7:0] rot_full;
    logic [3:0] req_rot;
    logic [1:0] off;
    logic [1:0] win;
    logic       req_any;
    logic       start;
    logic       own_req;
    logic       hold_hit;

    // Rotate so bit 0 is the requester just after the last winner.
    always_comb begin
        rot_full = {req, req} >> (ptr_q + 2'd1);
        req_rot  = rot_full[3:0];
        off      = 2'd0;
        priority case (1'b1)
            req_rot[0]: off = 2'd0;
            req_rot[1]: off = 2'd1;
            req_rot[2]: off = 2'd2;
            req_rot[3]: off = 2'd3;
            default:    off = 2'd0;
        endcase
        win = ptr_q + 2'd1 + off;
    end

    assign req_any  = |req;
    assign start    = en && req_any;
    assign own_req  = req[idx_q];
    assign hold_hit = HOLD_EN && (cnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!own_req || hold_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A dropped request wins over the hold limit, so timeout stays low then.
    always_comb begin
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                if (start) begin
                    gnt_d = 4'b0001 << win;
                    idx_d = win;
                    ptr_d = win;
                    cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (!own_req) begin
                    gnt_d = 4'b0000;
                end else if (hold_hit) begin
                    gnt_d     = 4'b0000;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: gnt_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = (state_q == S_GRANT);
    assign timeout = timeout_q;

    a_onehot : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_busy_gnt : assert property (
        @(posedge clk) disable iff (!rst_n) (gnt_q != 4'b0000) == busy);
    a_to_idle : assert property (
        @(posedge clk) disable iff (!rst_n) timeout_q |-> !busy);

endmodule
